// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and baud-rate helper shared by both ends of the UART link
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

   function automatic int clks_per_bit(input int clk_freq, input int baudrate);
      return clk_freq / baudrate;
   endfunction

endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchronizer for one asynchronous input
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset, loads RST_VAL into both flops
//   i_d     : asynchronous input
//   o_q     : synchronized output
module uart_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_q;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_meta <= RST_VAL;
         r_q    <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_q    <= r_meta;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style serial receiver, LSB first, mid-bit sampling
//   i_clk          : clock, rising edge
//   i_rst_n        : synchronous active-low reset
//   i_rx_line      : serial line, idle high, asynchronous to i_clk
//   o_receive_data : last good word, held until the next good frame
//   o_rx_ready     : one-cycle pulse when o_receive_data is updated
//   o_frame_error  : one-cycle pulse when the stop bit is sampled low
//   o_busy         : high while a frame is in progress
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 1036800,
   parameter int BAUDRATE   = 115200,
   parameter int DATA_WIDTH = 7
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_rx_line,
   output logic [DATA_WIDTH-1:0] o_receive_data,
   output logic                  o_rx_ready,
   output logic                  o_frame_error,
   output logic                  o_busy
);

   localparam int CPB  = clks_per_bit(CLK_FREQ, BAUDRATE);
   localparam int HALF = CPB / 2;
   localparam int CW   = $clog2(CPB);
   localparam int BW   = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
   localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
   localparam logic [BW-1:0] LAST    = BW'(DATA_WIDTH - 1);

   uart_state_t           r_state, w_next;
   logic [CW-1:0]         r_baud, w_baud_nxt;
   logic [BW-1:0]         r_bit, w_bit_nxt;
   logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
   logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
   logic                  r_ready, w_ready_nxt;
   logic                  r_ferr, w_ferr_nxt;
   logic                  r_prev;
   logic                  w_sync;
   logic                  w_fall;

   uart_sync #(.RST_VAL(1'b1)) u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_rx_line),
      .o_q     (w_sync)
   );

   // A line held low never produces a 1->0 transition, so a break cannot retrigger.
   assign w_fall = r_prev & ~w_sync;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_data  <= '0;
         r_ready <= 1'b0;
         r_ferr  <= 1'b0;
         r_prev  <= 1'b1;
      end else begin
         r_state <= w_next;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_data  <= w_data_nxt;
         r_ready <= w_ready_nxt;
         r_ferr  <= w_ferr_nxt;
         r_prev  <= w_sync;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_baud_nxt  = r_baud + 1'b1;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_data_nxt  = r_data;
      w_ready_nxt = 1'b0;
      w_ferr_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            w_baud_nxt = '0;
            w_bit_nxt  = '0;
            w_next     = w_fall ? START : IDLE;
         end
         START: if (r_baud == HALF_M1) begin
            w_baud_nxt = '0;
            w_bit_nxt  = '0;
            w_next     = w_sync ? IDLE : DATA;
         end
         DATA: if (r_baud == CPB_M1) begin
            w_baud_nxt  = '0;
            w_shift_nxt = DATA_WIDTH'({w_sync, r_shift} >> 1);
            w_bit_nxt   = r_bit + 1'b1;
            w_next      = (r_bit == LAST) ? STOP : DATA;
         end
         STOP: if (r_baud == CPB_M1) begin
            // Leaving at mid-stop-bit lets a start bit follow with no idle gap.
            w_baud_nxt  = '0;
            w_next      = IDLE;
            w_ready_nxt = w_sync;
            w_ferr_nxt  = ~w_sync;
            w_data_nxt  = w_sync ? r_shift : r_data;
         end
         default: w_next = IDLE;
      endcase
   end

   assign o_receive_data = r_data;
   assign o_rx_ready     = r_ready;
   assign o_frame_error  = r_ferr;
   assign o_busy         = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx
module tb_uart_rx;

   localparam int CPB = 9;
   localparam int DW  = 7;
   localparam int LAT = 78;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          rx_line;
   logic [DW-1:0] receive_data;
   logic          rx_ready;
   logic          frame_error;
   logic          busy;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int rdy_q[$];
   int rdy_t[$];
   int ferr_cnt = 0;
   int busy_cnt = 0;
   int both_cnt = 0;

   uart_rx #(.CLK_FREQ(1036800), .BAUDRATE(115200), .DATA_WIDTH(DW)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_rx_line      (rx_line),
      .o_receive_data (receive_data),
      .o_rx_ready     (rx_ready),
      .o_frame_error  (frame_error),
      .o_busy         (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_ready) begin
         rdy_q.push_back(int'(receive_data));
         rdy_t.push_back(cyc);
      end
      if (frame_error) ferr_cnt++;
      if (busy) busy_cnt++;
      if (rx_ready && frame_error) both_cnt++;
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic hold(input logic v, input int n);
      rx_line = v;
      repeat (n) @(negedge clk);
   endtask

   // Drives a full frame from a negedge; t0 is the first rising edge that samples the start bit.
   task automatic send(input logic [DW-1:0] d, input logic stop, output int t0);
      t0 = cyc + 1;
      hold(1'b0, CPB);
      for (int i = 0; i < DW; i++) hold(d[i], CPB);
      hold(stop, CPB);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_data"}, int'(receive_data), 0);
      check({tag, "_rdy"}, int'(rx_ready), 0);
      check({tag, "_ferr"}, int'(frame_error), 0);
      check({tag, "_busy"}, int'(busy), 0);
   endtask

   initial begin
      int t0, t1, b, bb, bf;
      logic [DW-1:0] rom [6];
      rom = '{7'h00, 7'h7F, 7'h2A, 7'h55, 7'h01, 7'h40};
      rx_line = 1'b1;
      rst_n   = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("idle_busy", int'(busy), 0);

      b = rdy_q.size(); bb = busy_cnt; bf = ferr_cnt;
      send(7'h55, 1'b1, t0);
      repeat (10) @(negedge clk);
      check("single_cnt", rdy_q.size() - b, 1);
      if (rdy_q.size() > b) begin
         check("single_data", rdy_q[b], 'h55);
         check("single_lat", rdy_t[b] - t0, LAT);
      end
      check("single_busy", busy_cnt - bb, LAT - 2);
      check("single_ferr", ferr_cnt - bf, 0);
      check("single_hold", int'(receive_data), 'h55);

      b = rdy_q.size();
      send(7'h41, 1'b1, t0);
      send(7'h7F, 1'b1, t1);
      repeat (10) @(negedge clk);
      check("b2b_cnt", rdy_q.size() - b, 2);
      if (rdy_q.size() > b + 1) begin
         check("b2b_d0", rdy_q[b], 'h41);
         check("b2b_d1", rdy_q[b+1], 'h7F);
         check("b2b_gap", rdy_t[b+1] - rdy_t[b], (DW + 2) * CPB);
         check("b2b_lat1", rdy_t[b+1] - t1, LAT);
      end

      b = rdy_q.size(); bb = busy_cnt; bf = ferr_cnt;
      hold(1'b0, 3);
      hold(1'b1, 4);
      check("glitch_busy6", int'(busy), 0);
      check("glitch_busy_len", busy_cnt - bb, 4);
      repeat (100) @(negedge clk);
      check("glitch_rdy", rdy_q.size() - b, 0);
      check("glitch_ferr", ferr_cnt - bf, 0);
      check("glitch_data", int'(receive_data), 'h7F);

      send(7'h11, 1'b1, t0);
      b = rdy_q.size(); bf = ferr_cnt;
      send(7'h2A, 1'b0, t0);
      hold(1'b0, 200);
      check("ferr_cnt", ferr_cnt - bf, 1);
      check("ferr_rdy", rdy_q.size() - b, 0);
      check("ferr_data", int'(receive_data), 'h11);
      check("ferr_break_busy", int'(busy), 0);
      hold(1'b1, 20);
      check("ferr_rise_busy", int'(busy), 0);
      check("ferr_cnt_after", ferr_cnt - bf, 1);

      b = rdy_q.size(); bf = ferr_cnt;
      hold(1'b0, CPB);
      hold(1'b1, CPB);
      hold(1'b1, CPB);
      hold(1'b0, 4);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_idle_outputs("midrst");
      hold(1'b1, 2);
      rst_n = 1'b1;
      hold(1'b1, 60);
      check("midrst_busy", int'(busy), 0);
      send(7'h0F, 1'b1, t0);
      repeat (10) @(negedge clk);
      check("midrst_cnt", rdy_q.size() - b, 1);
      if (rdy_q.size() > b) check("midrst_data", rdy_q[b], 'h0F);
      check("midrst_ferr", ferr_cnt - bf, 0);

      b = rdy_q.size();
      for (int i = 0; i < 6; i++) send(rom[i], 1'b1, t0);
      repeat (20) @(negedge clk);
      check("loop_cnt", rdy_q.size() - b, 6);
      for (int i = 0; i < 6; i++)
         if (rdy_q.size() > b + i) check($sformatf("loop_d%0d", i), rdy_q[b+i], int'(rom[i]));
      check("strobe_overlap", both_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
